// File: rtl/simon_playback_seq.sv
// Playback sequencer for the Simon datapath: reads pattern memory entries 0..len-1 and
// shows each for a hold time followed by a blank gap, once or in a continuous loop.
module simon_playback_seq #(
    parameter int ADDR_W = 6,
    parameter int DATA_W = 4,
    parameter int TMR_W  = 16
) (
    input  logic              pclk,
    input  logic              rst,
    input  logic              start,
    input  logic              abort,
    input  logic              loop,
    input  logic [ADDR_W:0]   seq_len,
    input  logic [TMR_W-1:0]  hold_cycles,
    input  logic [TMR_W-1:0]  gap_cycles,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_rd_en,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic [DATA_W-1:0] disp_pattern,
    output logic              disp_valid,
    output logic [ADDR_W-1:0] cur_idx,
    output logic              busy,
    output logic              done
);

    localparam logic [ADDR_W:0] MAX_LEN = (ADDR_W + 1)'(1) << ADDR_W;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_FETCH = 3'd1,
        S_WAIT  = 3'd2,
        S_SHOW  = 3'd3,
        S_GAP   = 3'd4
    } state_t;

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   idx_q, idx_d;
    logic [TMR_W-1:0]    tmr_q, tmr_d;
    logic [DATA_W-1:0]   disp_q, disp_d;
    logic [ADDR_W:0]     len_q, len_d;
    logic [TMR_W-1:0]    hold_q, hold_d;
    logic [TMR_W-1:0]    gap_q, gap_d;
    logic                loop_q, loop_d;
    logic                done_q, done_d;
    logic                advance;
    logic                last_entry;

    // Lengths beyond the memory depth saturate to the full memory.
    function automatic logic [ADDR_W:0] clamp_len(input logic [ADDR_W:0] l);
        return (l > MAX_LEN) ? MAX_LEN : l;
    endfunction

    always_ff @(posedge pclk) begin
        if (rst) begin
            state_q <= S_IDLE;
            idx_q   <= '0;
            tmr_q   <= '0;
            disp_q  <= '0;
            len_q   <= '0;
            hold_q  <= '0;
            gap_q   <= '0;
            loop_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            tmr_q   <= tmr_d;
            disp_q  <= disp_d;
            len_q   <= len_d;
            hold_q  <= hold_d;
            gap_q   <= gap_d;
            loop_q  <= loop_d;
            done_q  <= done_d;
        end
    end

    assign last_entry = ({1'b0, idx_q} == (len_q - (ADDR_W + 1)'(1)));

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        tmr_d   = tmr_q;
        disp_d  = disp_q;
        len_d   = len_q;
        hold_d  = hold_q;
        gap_d   = gap_q;
        loop_d  = loop_q;
        done_d  = 1'b0;
        advance = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (start && !abort) begin
                    len_d  = clamp_len(seq_len);
                    hold_d = hold_cycles;
                    gap_d  = gap_cycles;
                    loop_d = loop;
                    idx_d  = '0;
                    if (clamp_len(seq_len) == '0) begin
                        done_d = 1'b1;
                    end else begin
                        state_d = S_FETCH;
                    end
                end
            end
            S_FETCH: state_d = S_WAIT;
            S_WAIT: begin
                disp_d  = mem_rdata;
                // A zero hold still shows the entry for one cycle.
                tmr_d   = (hold_q == '0) ? '0 : hold_q - TMR_W'(1);
                state_d = S_SHOW;
            end
            S_SHOW: begin
                if (tmr_q == '0) begin
                    if (gap_q != '0) begin
                        tmr_d   = gap_q - TMR_W'(1);
                        state_d = S_GAP;
                    end else begin
                        advance = 1'b1;
                    end
                end else begin
                    tmr_d = tmr_q - TMR_W'(1);
                end
            end
            S_GAP: begin
                if (tmr_q == '0) begin
                    advance = 1'b1;
                end else begin
                    tmr_d = tmr_q - TMR_W'(1);
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (advance) begin
            if (!last_entry) begin
                idx_d   = idx_q + ADDR_W'(1);
                state_d = S_FETCH;
            end else if (loop_q) begin
                idx_d   = '0;
                state_d = S_FETCH;
            end else begin
                state_d = S_IDLE;
                done_d  = 1'b1;
            end
        end

        if (abort && (state_q != S_IDLE)) begin
            state_d = S_IDLE;
            done_d  = 1'b0;
        end
    end

    always_comb begin
        busy         = (state_q != S_IDLE);
        mem_rd_en    = (state_q == S_FETCH);
        mem_addr     = idx_q;
        cur_idx      = idx_q;
        disp_valid   = (state_q == S_SHOW);
        disp_pattern = (state_q == S_SHOW) ? disp_q : '0;
        done         = done_q;
    end

endmodule
